data_bus_arbiter: RTL and testbench



---
 rtl/data_bus_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Purpose  : N-master to one-slave data bus arbiter. Grants are round-robin.
//            BYTE/HALF/WORD sizes are alignment-checked before the slave is
//            strobed. Every transaction ends in a one-cycle m_ready pulse.
// Options  : define DATA_BUS_ARB_TIMEOUT_EN to add a slave-wait watchdog that
//            ends a stalled access with an error after TIMEOUT wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dataOut,
    input  logic [NUM_MASTERS*2-1:0]      m_memType,
    output logic [NUM_MASTERS*DATA_W-1:0] m_dataIn,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic                          s_read,
    output logic                          s_write,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_dataOut,
    output logic [1:0]                    s_memType,
    input  logic [DATA_W-1:0]             s_dataIn,
    input  logic                          s_ready
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    localparam logic [1:0] c_MT_HALF = 2'd1;
    localparam logic [1:0] c_MT_WORD = 2'd2;
    localparam logic [1:0] c_MT_RSVD = 2'd3;

    // Reject configurations the datapath was not built for.
    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || DATA_W != 32 || TIMEOUT < 1) begin : g_param_check
            $error("data_bus_arbiter: unsupported parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [IDX_W-1:0]          r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]          r_gnt, w_gnt_nxt;
    logic                      r_rd, w_rd_nxt;
    logic                      r_wr, w_wr_nxt;
    logic                      r_ill, w_ill_nxt;
    logic [ADDR_W-1:0]         r_addr, w_addr_nxt;
    logic [DATA_W-1:0]         r_wdata, w_wdata_nxt;
    logic [1:0]                r_mtype, w_mtype_nxt;

    logic [NUM_MASTERS*DATA_W-1:0] w_m_dataIn_nxt;
    logic [NUM_MASTERS-1:0]        w_m_ready_nxt;
    logic [NUM_MASTERS-1:0]        w_m_err_nxt;
    logic                          w_s_read_nxt;
    logic                          w_s_write_nxt;
    logic [ADDR_W-1:0]             w_s_addr_nxt;
    logic [DATA_W-1:0]             w_s_dataOut_nxt;
    logic [1:0]                    w_s_memType_nxt;

    logic                          w_found;
    logic [IDX_W-1:0]              w_sel;
    logic [IDX_W:0]                w_k;
    logic                          w_bad;

`ifdef DATA_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]              r_wait, w_wait_nxt;
`endif

    // Round-robin search: first master with a pending request at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_k     = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_k = {1'b0, r_ptr} + (IDX_W+1)'(i);
            if (w_k >= (IDX_W+1)'(NUM_MASTERS)) begin
                w_k = w_k - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!w_found && (m_read[w_k[IDX_W-1:0]] || m_write[w_k[IDX_W-1:0]])) begin
                w_found = 1'b1;
                w_sel   = w_k[IDX_W-1:0];
            end
        end
    end

    // Illegal opcode, reserved size or misaligned HALF/WORD never reaches the slave.
    assign w_bad = r_ill
                 | (r_mtype == c_MT_RSVD)
                 | ((r_mtype == c_MT_HALF) & r_addr[0])
                 | ((r_mtype == c_MT_WORD) & (r_addr[1:0] != 2'b00));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_rd_nxt        = r_rd;
        w_wr_nxt        = r_wr;
        w_ill_nxt       = r_ill;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_mtype_nxt     = r_mtype;
        w_m_dataIn_nxt  = m_dataIn;
        w_m_ready_nxt   = '0;
        w_m_err_nxt     = '0;
        w_s_read_nxt    = s_read;
        w_s_write_nxt   = s_write;
        w_s_addr_nxt    = s_addr;
        w_s_dataOut_nxt = s_dataOut;
        w_s_memType_nxt = s_memType;
`ifdef DATA_BUS_ARB_TIMEOUT_EN
        w_wait_nxt      = r_wait;
`endif
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = w_sel;
                    w_rd_nxt    = m_read[w_sel];
                    w_wr_nxt    = m_write[w_sel];
                    w_ill_nxt   = m_read[w_sel] & m_write[w_sel];
                    w_addr_nxt  = m_addr[w_sel*ADDR_W +: ADDR_W];
                    w_wdata_nxt = m_dataOut[w_sel*DATA_W +: DATA_W];
                    w_mtype_nxt = m_memType[w_sel*2 +: 2];
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_bad) begin
                    w_m_ready_nxt[r_gnt]                    = 1'b1;
                    w_m_err_nxt[r_gnt]                      = 1'b1;
                    w_m_dataIn_nxt[r_gnt*DATA_W +: DATA_W]  = '0;
                    w_state_nxt                             = RESP;
                end else begin
                    w_s_read_nxt    = r_rd;
                    w_s_write_nxt   = r_wr;
                    w_s_addr_nxt    = r_addr;
                    w_s_dataOut_nxt = r_wdata;
                    w_s_memType_nxt = r_mtype;
`ifdef DATA_BUS_ARB_TIMEOUT_EN
                    w_wait_nxt      = '0;
`endif
                    w_state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    w_s_read_nxt                           = 1'b0;
                    w_s_write_nxt                          = 1'b0;
                    w_m_ready_nxt[r_gnt]                   = 1'b1;
                    w_m_dataIn_nxt[r_gnt*DATA_W +: DATA_W] = r_rd ? s_dataIn : '0;
                    w_state_nxt                            = RESP;
                end
`ifdef DATA_BUS_ARB_TIMEOUT_EN
                else if (r_wait == CNT_W'(TIMEOUT)) begin
                    w_s_read_nxt                           = 1'b0;
                    w_s_write_nxt                          = 1'b0;
                    w_m_ready_nxt[r_gnt]                   = 1'b1;
                    w_m_err_nxt[r_gnt]                     = 1'b1;
                    w_m_dataIn_nxt[r_gnt*DATA_W +: DATA_W] = '0;
                    w_state_nxt                            = RESP;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
`endif
            end
            RESP: begin
                w_ptr_nxt   = (r_gnt == IDX_W'(NUM_MASTERS-1)) ? '0 : r_gnt + 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, latched request and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_ill     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_mtype   <= '0;
            m_dataIn  <= '0;
            m_ready   <= '0;
            m_err     <= '0;
            s_read    <= 1'b0;
            s_write   <= 1'b0;
            s_addr    <= '0;
            s_dataOut <= '0;
            s_memType <= '0;
`ifdef DATA_BUS_ARB_TIMEOUT_EN
            r_wait    <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_ill     <= w_ill_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_mtype   <= w_mtype_nxt;
            m_dataIn  <= w_m_dataIn_nxt;
            m_ready   <= w_m_ready_nxt;
            m_err     <= w_m_err_nxt;
            s_read    <= w_s_read_nxt;
            s_write   <= w_s_write_nxt;
            s_addr    <= w_s_addr_nxt;
            s_dataOut <= w_s_dataOut_nxt;
            s_memType <= w_s_memType_nxt;
`ifdef DATA_BUS_ARB_TIMEOUT_EN
            r_wait    <= w_wait_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Purpose  : Self-checking bench for data_bus_arbiter with a response
//            scoreboard, a slave-access scoreboard and a behavioural slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_read, m_write, m_ready, m_err;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_dataOut, m_dataIn;
    logic [N*2-1:0]    m_memType;
    logic              s_read, s_write, s_ready;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_dataOut, s_dataIn;
    logic [1:0]        s_memType;

    data_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_dataOut(m_dataOut),
        .m_memType(m_memType), .m_dataIn(m_dataIn), .m_ready(m_ready), .m_err(m_err),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_dataOut(s_dataOut),
        .s_memType(s_memType), .s_dataIn(s_dataIn), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [1:0]   mt;
        bit           err;
        bit           strobe;
        logic [31:0]  data;
        int           lat;
        int           t0;
    } txn_t;

    txn_t pend[N];
    txn_t exp_q[$];
    txn_t sq[$];
    int   reissue[N];
    int   model_ptr = 0;
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   slave_delay_fixed = -1;
    bit   slave_mute = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave read data is a fixed function of the address; 0x100 yields 0xCAFEBABE.
    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return ((a - 32'h100) * 32'h9E3779B1) ^ 32'hCAFEBABE;
    endfunction

    // Reference behaviour of one request: size/alignment rules decide error vs access.
    function automatic txn_t make(input int idx, input bit rd, input bit wr,
                                  input logic [31:0] addr, input logic [1:0] mt, input int lat);
        txn_t t;
        t.idx    = idx;
        t.rd     = rd;
        t.wr     = wr;
        t.addr   = addr;
        t.mt     = mt;
        t.wdata  = $urandom;
        t.lat    = lat;
        t.t0     = 0;
        t.err    = (rd && wr) || (mt == 2'd3) || (mt == 2'd1 && addr[0]) ||
                   (mt == 2'd2 && addr[1:0] != 2'b00);
        t.strobe = !t.err;
        t.data   = (rd && !t.err) ? slave_word(addr) : 32'h0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_m_ready"},   32'(m_ready),   32'h0);
        chk({tag, "_m_err"},     32'(m_err),     32'h0);
        chk({tag, "_s_read"},    32'(s_read),    32'h0);
        chk({tag, "_s_write"},   32'(s_write),   32'h0);
        chk({tag, "_s_addr"},    s_addr,         32'h0);
        chk({tag, "_s_dataOut"}, s_dataOut,      32'h0);
        chk({tag, "_s_memType"}, 32'(s_memType), 32'h0);
        chk({tag, "_m_dataIn_zero"}, 32'(m_dataIn == '0), 32'h1);
    endtask

    // Drive the masked masters at once; expected completion order is round-robin from the pointer.
    task automatic launch(input bit [N-1:0] mask);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                pend[i].t0             = cyc;
                m_read[i]              = pend[i].rd;
                m_write[i]             = pend[i].wr;
                m_addr[i*AW +: AW]     = pend[i].addr;
                m_dataOut[i*DW +: DW]  = pend[i].wdata;
                m_memType[i*2 +: 2]    = pend[i].mt;
            end
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (model_ptr + k) % N;
            if (mask[i]) begin
                exp_q.push_back(pend[i]);
                if (pend[i].strobe) sq.push_back(pend[i]);
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
            sq.delete();
            m_read  = '0;
            m_write = '0;
            rst     = 1'b1;
            @(negedge clk);
            rst       = 1'b0;
            model_ptr = 0;
        end
    endtask

    // Response monitor: pops the scoreboard on every m_ready pulse.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst && m_ready != '0) begin
                chk("ready_onehot", 32'($countones(m_ready)), 32'h1);
                for (int i = 0; i < N; i++) begin
                    if (m_ready[i]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL unexpected_ready: master %0d pulsed, required no pulse", i);
                            m_read[i]  = 1'b0;
                            m_write[i] = 1'b0;
                        end else begin
                            t = exp_q.pop_front();
                            chk("grant_order", 32'(i), 32'(t.idx));
                            chk("m_err", 32'(m_err[i]), 32'(t.err));
                            chk("m_dataIn", m_dataIn[i*DW +: DW], t.data);
                            if (t.lat >= 0) chk("latency", 32'(cyc - t.t0), 32'(t.lat));
                            model_ptr = (t.idx + 1) % N;
                            if (reissue[t.idx] > 0 && t.idx == i) begin
                                reissue[t.idx]--;
                                t.lat = -1;
                                exp_q.push_back(t);
                                if (t.strobe) sq.push_back(t);
                            end else begin
                                m_read[i]  = 1'b0;
                                m_write[i] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Behavioural slave: checks each new access, answers after a delay unless muted.
    initial begin
        bit   active;
        int   wcnt;
        txn_t t;
        active   = 1'b0;
        wcnt     = 0;
        s_ready  = 1'b0;
        s_dataIn = '0;
        forever begin
            @(negedge clk);
            s_ready = 1'b0;
            if (rst || !(s_read || s_write)) begin
                active = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                wcnt   = (slave_delay_fixed >= 0) ? slave_delay_fixed : $urandom_range(0, 3);
                if (sq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_strobe: addr %h, required no slave access", s_addr);
                end else begin
                    t = sq.pop_front();
                    chk("s_addr", s_addr, t.addr);
                    chk("s_read", 32'(s_read), 32'(t.rd));
                    chk("s_write", 32'(s_write), 32'(t.wr));
                    chk("s_memType", 32'(s_memType), 32'(t.mt));
                    if (t.wr) chk("s_dataOut", s_dataOut, t.wdata);
                end
            end
            if (active && !slave_mute) begin
                if (wcnt == 0) begin
                    s_ready  = 1'b1;
                    s_dataIn = slave_word(s_addr);
                    active   = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    // Main stimulus sequence.
    initial begin
        bit [N-1:0]  mask;
        int          kind;
        logic [31:0] a;
        for (int i = 0; i < N; i++) reissue[i] = 0;
        m_read = '0; m_write = '0; m_addr = '0; m_dataOut = '0; m_memType = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Word read at 0x100, slave answers two cycles after the strobe.
        slave_delay_fixed = 2;
        pend[0] = make(0, 1'b1, 1'b0, 32'h100, 2'd2, 5);
        pend[0].data = 32'hCAFEBABE;
        launch(4'b0001);
        wait_done("cafebabe");

        // Zero-wait slave write.
        slave_delay_fixed = 0;
        pend[2] = make(2, 1'b0, 1'b1, 32'h200, 2'd2, 3);
        launch(4'b0100);
        wait_done("zero_wait");
        slave_delay_fixed = -1;

        // Misaligned / reserved-size requests: error at T+2, no strobe.
        pend[0] = make(0, 1'b0, 1'b1, 32'h101, 2'd1, 2);
        launch(4'b0001);
        wait_done("half_misaligned");
        pend[1] = make(1, 1'b1, 1'b0, 32'h102, 2'd2, 2);
        launch(4'b0010);
        wait_done("word_misaligned");
        pend[3] = make(3, 1'b1, 1'b0, 32'h104, 2'd3, 2);
        launch(4'b1000);
        wait_done("reserved_size");

        // Illegal read+write on master 1 alongside legal neighbours.
        pend[0] = make(0, 1'b1, 1'b0, 32'h410, 2'd2, -1);
        pend[1] = make(1, 1'b1, 1'b1, 32'h420, 2'd2, -1);
        pend[3] = make(3, 1'b0, 1'b1, 32'h432, 2'd1, -1);
        launch(4'b1011);
        wait_done("illegal_rw");

        // Masters 0 and 2 hold their requests: grants alternate.
        pend[0] = make(0, 1'b1, 1'b0, 32'h500, 2'd2, -1);
        pend[2] = make(2, 1'b0, 1'b1, 32'h601, 2'd0, -1);
        reissue[0] = 3;
        reissue[2] = 3;
        launch(4'b0101);
        wait_done("alternate");

        // Grant to the last master wraps the pointer to 0.
        pend[3] = make(3, 1'b1, 1'b0, 32'h700, 2'd0, -1);
        launch(4'b1000);
        wait_done("wrap_a");
        pend[0] = make(0, 1'b1, 1'b0, 32'h710, 2'd2, -1);
        pend[3] = make(3, 1'b1, 1'b0, 32'h720, 2'd2, -1);
        launch(4'b1001);
        wait_done("wrap_b");

`ifdef DATA_BUS_ARB_TIMEOUT_EN
        // Silent slave: watchdog ends the access with an error, then the next requester runs.
        slave_mute = 1'b1;
        pend[0] = make(0, 1'b1, 1'b0, 32'h40, 2'd2, 11);
        pend[0].err  = 1'b1;
        pend[0].data = 32'h0;
        launch(4'b0001);
        wait_done("watchdog");
        slave_mute = 1'b0;
        pend[1] = make(1, 1'b1, 1'b0, 32'h44, 2'd2, -1);
        launch(4'b0010);
        wait_done("after_watchdog");
`endif

        // Reset in BUSY aborts the transfer silently.
        slave_mute = 1'b1;
        pend[1] = make(1, 1'b1, 1'b0, 32'h300, 2'd2, -1);
        launch(4'b0010);
        for (int k = 0; k < 20 && !s_read; k++) @(negedge clk);
        chk("busy_reached", 32'(s_read), 32'h1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        sq.delete();
        model_ptr = 0;
        m_read  = '0;
        m_write = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        slave_mute = 1'b0;
        repeat (10) @(negedge clk);
        pend[1] = make(1, 1'b1, 1'b0, 32'h300, 2'd2, -1);
        launch(4'b0010);
        wait_done("post_reset");

        // Randomized batches against the reference model.
        for (int b = 0; b < 40; b++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    kind = $urandom_range(0, 9);
                    a    = $urandom;
                    if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
                    pend[i] = make(i, (kind == 0) || (kind < 6), (kind == 0) || (kind >= 6),
                                   a, 2'($urandom_range(0, 3)), -1);
                end
            end
            launch(mask);
            wait_done("random");
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
